pmod_ad1_stream_packer: RTL
===========================

Name: pmod_ad1_stream_packer

Overview:
- Downstream consumer of the dual-channel PmodAD1 SPI poller; takes its drdy/dout0/dout1 sample pairs.
- Extracts the 12-bit conversion results and optionally averages 2^AVG_LOG2 consecutive pairs.
- Packs each pair into a 32-bit word, buffers it in a small FIFO and presents it as an AXI4-Stream master with packet framing.
- Sits between the SPI poller and a DMA / stream interconnect.

Parameters:
- AVG_LOG2, 0, log2 of samples averaged per output word (0..4); 0 = pass-through.
- FIFO_DEPTH, 16, FIFO entries; power of two, 4..256.
- PACKET_LEN, 256, output words per packet; tlast on the last word; >= 1.

Ports:
- clk  in  1  system clock, same domain as the SPI poller.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable; level.
- drdy  in  1  data-ready level from the SPI poller; high for many cycles per sample.
- din0  in  16  channel 0 word; bits [15:12] ignored.
- din1  in  16  channel 1 word; bits [15:12] ignored.
- m_axis_tdata  out  32  {4'b0, ch1[11:0], 4'b0, ch0[11:0]}.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  end of packet.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- clr_ovf  in  1  single-cycle pulse; clears overflow and ovf_cnt.
- ovf_cnt  out  16  count of dropped words, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_n=0, asynchronous): drdy_q=0, accumulators=0, sample counter=0, FIFO empty, beat counter=0, tvalid=0, tlast=0, overflow=0, ovf_cnt=0, fill=0.
- Capture: drdy_q registers drdy; capture strobe cap = drdy & ~drdy_q & en. Exactly one capture per drdy high period.
- Accumulate:
  - Two accumulators, 12+AVG_LOG2 bits each; a sample counter counts 0..2^AVG_LOG2-1.
  - On cap: acc += din[11:0].
  - When the counter reaches its terminal value, the completed word is (acc + din[11:0]) >> AVG_LOG2 (truncating, no rounding). On that same edge the word is pushed and acc and counter return to 0.
  - AVG_LOG2=0: every cap pushes directly.
- en low: no captures; accumulators and sample counter are cleared on every cycle en=0 (a partial average is discarded). FIFO draining continues.
- Latency: with AVG_LOG2=0 and an empty FIFO, tvalid rises on the cycle after the edge at which cap=1. tdata is valid in that same cycle.
- FIFO behaviour:
  - First-word-fall-through; tdata driven from the head entry.
  - Pointers carry one extra wrap bit.
  - pop = tvalid & tready.
  - push succeeds only if the FIFO is not full at the start of the cycle; a simultaneous pop does not free space for that push.
  - A push while full drops the word, sets overflow and increments ovf_cnt (saturating).
  - Simultaneous pop and accepted push leave fill unchanged.
- clr_ovf coinciding with a drop: clear wins; overflow=0, ovf_cnt=0.
- AXI rules:
  - tvalid = !empty.
  - tdata and tlast are held stable while tvalid & !tready.
  - The beat counter increments on each pop and wraps to 0 after PACKET_LEN-1.
  - tlast = (beat counter == PACKET_LEN-1) & tvalid. PACKET_LEN=1 gives tlast on every beat.
- Reset mid-packet: the FIFO and beat counter clear; the stream restarts at beat 0. Downstream must tolerate a truncated packet.
- No combinational path from m_axis_tready to m_axis_tvalid.

Decomposition:
- Shared package pmod_ad1_pkg holds:
  - AD1_DATA_W=12 and AD1_WORD_W=16;
  - the packed-word layout constants: CH0_LSB=0, CH1_LSB=16, PAD_W=4.
- One sub-module is natural: sync_fifo_fwft (parameters WIDTH, DEPTH; ports push, din, pop, dout, full, empty, fill). It must be reusable by the other Pmod stream blocks.
- Edge detect, averaging and AXI framing stay in the top module.

Test Plan:
- AVG_LOG2=0, tready=1, drdy pulses with din0=16'h0ABC, din1=16'h0123 -> one beat with tdata=32'h01230ABC, tvalid high 1 cycle after cap.
- din0=16'hFABC (upper nibble set) -> tdata[15:0]=16'h0ABC; upper bits are discarded.
- AVG_LOG2=2, ch0 samples 100, 101, 102, 104 -> a single word with ch0=101 (407>>2). No word is produced after only 3 samples.
- tready=0, FIFO_DEPTH=16, 18 drdy pulses -> fill=16; overflow=1; ovf_cnt=2; the first 16 words are intact in order. A clr_ovf pulse then gives overflow=0, ovf_cnt=0.
- PACKET_LEN=4, 9 words with random tready stalls -> tlast on beats 4 and 8 only; tdata stable during stalls.
- rst_n asserted mid-packet with 5 words buffered -> tvalid=0 and fill=0 immediately (asynchronous). After release, the next packet's tlast falls on its 4th beat.

Source files
------------

// File: rtl/pmod_ad1_pkg.sv
// Shared definitions for the PmodAD1 stream blocks: sample widths and the
// layout of the 32-bit packed channel-pair word.
package pmod_ad1_pkg;

  localparam int AD1_DATA_W = 12;
  localparam int AD1_WORD_W = 16;
  localparam int CH0_LSB    = 0;
  localparam int CH1_LSB    = 16;
  localparam int PAD_W      = 4;
  localparam int PACKED_W   = 2 * (AD1_DATA_W + PAD_W);

  function automatic logic [PACKED_W-1:0] pack_pair(
    input logic [AD1_DATA_W-1:0] ch0,
    input logic [AD1_DATA_W-1:0] ch1
  );
    logic [PACKED_W-1:0] word;
    word = '0;
    word[CH0_LSB +: AD1_DATA_W] = ch0;
    word[CH1_LSB +: AD1_DATA_W] = ch1;
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; dout always shows the head entry.
// Pointers carry an extra wrap bit so full/empty need no separate flag.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      fill
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign fill    = wr_q - rd_q;
  assign dout    = mem_q[rd_q[AW-1:0]];
  // Space is judged at the start of the cycle: a same-cycle pop never admits a push.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + (AW+1)'(1);
    if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pmod_ad1_stream_packer.sv
// Captures PmodAD1 sample pairs on each drdy rise, optionally averages them,
// and streams packed words out over AXI4-Stream with tlast framing.
module pmod_ad1_stream_packer
  import pmod_ad1_pkg::*;
#(
  parameter int AVG_LOG2   = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int PACKET_LEN = 256,
  localparam int FILL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  drdy,
  input  logic [AD1_WORD_W-1:0] din0,
  input  logic [AD1_WORD_W-1:0] din1,
  output logic [PACKED_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [FILL_W-1:0]     fill,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic [15:0]           ovf_cnt
);

  localparam int ACC_W  = AD1_DATA_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

  logic                  drdy_q;
  logic                  cap;
  logic [ACC_W-1:0]      acc0_q, acc0_d, acc1_q, acc1_d;
  logic [ACC_W-1:0]      sum0, sum1, sh0, sh1;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_sample;
  logic                  push;
  logic [PACKED_W-1:0]   push_word;
  logic                  full, empty, pop;
  logic                  overflow_q, overflow_d;
  logic [15:0]           ovf_cnt_q, ovf_cnt_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  unused_bits;

  assign unused_bits = ^{din0[AD1_WORD_W-1:AD1_DATA_W], din1[AD1_WORD_W-1:AD1_DATA_W]};

  assign cap         = drdy && !drdy_q && en;
  assign sum0        = acc0_q + ACC_W'(din0[AD1_DATA_W-1:0]);
  assign sum1        = acc1_q + ACC_W'(din1[AD1_DATA_W-1:0]);
  assign sh0         = sum0 >> AVG_LOG2;
  assign sh1         = sum1 >> AVG_LOG2;
  // With AVG_LOG2=0 the counter is pinned at 0, so every capture is terminal.
  assign last_sample = (cnt_q == CNT_W'((1 << AVG_LOG2) - 1));
  assign push_word   = pack_pair(sh0[AD1_DATA_W-1:0], sh1[AD1_DATA_W-1:0]);

  always_comb begin
    acc0_d = acc0_q;
    acc1_d = acc1_q;
    cnt_d  = cnt_q;
    push   = 1'b0;
    if (!en) begin
      acc0_d = '0;
      acc1_d = '0;
      cnt_d  = '0;
    end else if (cap) begin
      if (last_sample) begin
        push   = 1'b1;
        acc0_d = '0;
        acc1_d = '0;
        cnt_d  = '0;
      end else begin
        acc0_d = sum0;
        acc1_d = sum1;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH(PACKED_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (push_word),
    .pop  (pop),
    .dout (m_axis_tdata),
    .full (full),
    .empty(empty),
    .fill (fill)
  );

  assign m_axis_tvalid = !empty;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = (beat_q == BEAT_W'(PACKET_LEN - 1)) && m_axis_tvalid;
  assign overflow      = overflow_q;
  assign ovf_cnt       = ovf_cnt_q;

  // A clear request takes priority over a drop in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    beat_d     = beat_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
      ovf_cnt_d  = '0;
    end else if (push && full) begin
      overflow_d = 1'b1;
      if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
    if (pop) begin
      beat_d = (beat_q == BEAT_W'(PACKET_LEN - 1)) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drdy_q     <= 1'b0;
      acc0_q     <= '0;
      acc1_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
      beat_q     <= '0;
    end else begin
      drdy_q     <= drdy;
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
      beat_q     <= beat_d;
    end
  end

endmodule
